// File: rtl/i2c_pkg.sv
// Shared I2C definitions: transfer states and address/direction constants.
package i2c_pkg;

    localparam int   I2C_ADDR_W  = 7;
    localparam logic I2C_RW_READ = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        WAIT_STOP
    } i2c_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// I2C line conditioner: brings SCL/SDA into the clk domain and flags SCL
// edges plus START/STOP bus conditions as single-cycle pulses.
module i2c_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_hist;
    logic                   sda_hist;
    logic                   scl_s;
    logic                   sda_s;

    // Synchronizer chains plus one history flop per line; everything idles high like a released bus
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_hist <= scl_s;
            sda_hist <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign sda_level = sda_s;
    assign scl_rise  = scl_s & ~scl_hist;
    assign scl_fall  = ~scl_s & scl_hist;
    assign start_det = sda_hist & ~sda_s & scl_s;
    assign stop_det  = ~sda_hist & sda_s & scl_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: matches a 7-bit address, receives write bytes into
// rx_data and serves read bytes from tx_data, acknowledging via open-drain SDA.
module i2c_target
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = I2C_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    input  logic [ADDR_W-1:0] own_addr,
    input  logic [7:0]        tx_data,
    output logic              tx_req,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              addr_match
);

    i2c_state_t        state;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic [7:0]        shift_next;
    logic              sda_oe_q;
    logic [ADDR_W-1:0] own_addr_q;
    logic              byte_done;
    logic              master_ack;

    logic sda_level;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_level(sda_level),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    assign shift_next = {shift[6:0], sda_level};

    // Reset gates the SDA pull combinationally so the line is let go within the reset cycle itself
    assign sda_oe = sda_oe_q & ~rst;

    // Transfer state machine: bus conditions win over bit events, data moves on SCL edges
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            sda_oe_q   <= 1'b0;
            own_addr_q <= '0;
            byte_done  <= 1'b0;
            master_ack <= 1'b0;
            tx_req     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            addr_match <= 1'b0;
        end else begin
            tx_req   <= 1'b0;
            rx_valid <= 1'b0;
            if (state == IDLE) begin
                own_addr_q <= own_addr;
            end
            if (start_det) begin
                state      <= ADDR;
                bit_cnt    <= 3'd0;
                sda_oe_q   <= 1'b0;
                busy       <= 1'b1;
                addr_match <= 1'b0;
                byte_done  <= 1'b0;
            end else if (stop_det) begin
                state      <= IDLE;
                sda_oe_q   <= 1'b0;
                busy       <= 1'b0;
                addr_match <= 1'b0;
                byte_done  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= shift_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (shift_next[7:1] == own_addr_q) begin
                                    addr_match <= 1'b1;
                                end else begin
                                    state <= WAIT_STOP;
                                end
                            end
                        end else if (scl_fall && addr_match) begin
                            sda_oe_q <= 1'b1;
                            state    <= ADDR_ACK;
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 3'd0;
                            if (shift[0] == I2C_RW_READ) begin
                                shift    <= tx_data;
                                tx_req   <= 1'b1;
                                sda_oe_q <= ~tx_data[7];
                                state    <= READ;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state    <= WRITE;
                            end
                        end
                    end
                    WRITE: begin
                        if (scl_rise) begin
                            shift   <= shift_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                rx_data   <= shift_next;
                                rx_valid  <= 1'b1;
                                byte_done <= 1'b1;
                            end
                        end else if (scl_fall && byte_done) begin
                            byte_done <= 1'b0;
                            sda_oe_q  <= 1'b1;
                            state     <= WRITE_ACK;
                        end
                    end
                    WRITE_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            state    <= WRITE;
                        end
                    end
                    READ: begin
                        if (scl_fall) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                sda_oe_q <= 1'b0;
                                state    <= READ_ACK;
                            end else begin
                                shift    <= {shift[6:0], shift[7]};
                                sda_oe_q <= ~shift[6];
                            end
                        end
                    end
                    READ_ACK: begin
                        if (scl_rise) begin
                            master_ack <= ~sda_level;
                        end else if (scl_fall) begin
                            if (master_ack) begin
                                shift    <= tx_data;
                                tx_req   <= 1'b1;
                                sda_oe_q <= ~tx_data[7];
                                bit_cnt  <= 3'd0;
                                state    <= READ;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state    <= WAIT_STOP;
                            end
                        end
                    end
                    WAIT_STOP: begin
                    end
                    default: begin
                        state    <= IDLE;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged bus master plus a transaction-level model
// of what the target must answer, received and request on each transfer.
module tb_i2c_target;

    localparam int H = 10;

    logic       clk;
    logic       rst;
    logic       m_scl;
    logic       m_sda;
    logic       sda_bus;
    logic       sda_oe;
    logic [6:0] own_addr;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       addr_match;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  rx_q[$];
    logic        exp_selected = 1'b0;
    logic        tx_expect    = 1'b0;
    logic [31:0] tx_word      = 32'h0;
    int          tx_idx       = 0;
    int          tx_req_cnt   = 0;
    int          rxv_cnt      = 0;
    logic        bus_busy     = 1'b0;
    logic [6:0]  model_own    = 7'h00;
    logic [7:0]  last_read    = 8'h00;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_target dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (m_scl),
        .sda_in    (sda_bus),
        .sda_oe    (sda_oe),
        .own_addr  (own_addr),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .addr_match(addr_match)
    );

    // Free-running system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
    endtask

    // One SCL period: master puts b on SDA mid-low, samples the wired bus mid-high
    task automatic clockBit(input logic b, output logic s);
        waitClk(H / 2);
        m_sda = b;
        waitClk(H / 2);
        m_scl = 1'b1;
        waitClk(H / 2);
        @(negedge clk);
        s = sda_bus;
        waitClk(H / 2);
        m_scl = 1'b0;
    endtask

    task automatic startCond();
        waitClk(H);
        m_sda = 1'b0;
        waitClk(H);
        m_scl = 1'b0;
    endtask

    task automatic repStart();
        waitClk(H / 2);
        m_sda = 1'b1;
        waitClk(H / 2);
        m_scl = 1'b1;
        waitClk(H / 2);
        m_sda = 1'b0;
        waitClk(H / 2);
        m_scl = 1'b0;
    endtask

    task automatic stopCond();
        waitClk(H / 2);
        m_sda = 1'b0;
        waitClk(H / 2);
        m_scl = 1'b1;
        waitClk(H / 2);
        m_sda = 1'b1;
        waitClk(H);
    endtask

    task automatic sendByte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clockBit(b[i], s);
        clockBit(1'b1, s);
        ack = ~s;
    endtask

    task automatic readByte(input logic send_ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clockBit(1'b1, s);
            b[i] = s;
        end
        clockBit(~send_ack, s);
    endtask

    task automatic finishStop(input string tag);
        stopCond();
        bus_busy     = 1'b0;
        exp_selected = 1'b0;
        waitClk(4);
        @(negedge clk);
        checkOutput({tag, "_busy_after_stop"}, busy, 1'b0);
        checkOutput({tag, "_match_after_stop"}, addr_match, 1'b0);
        checkOutput({tag, "_oe_after_stop"}, sda_oe, 1'b0);
    endtask

    // One transfer: selection follows from the address the target latched while the bus was idle
    task automatic applyStimulus(input string tag, input logic [6:0] addr, input logic rw,
                                 input int n, input logic [31:0] data, input logic do_stop);
        logic       sel;
        logic       ack;
        logic [7:0] b;
        if (!bus_busy) model_own = own_addr;
        sel = (addr == model_own);
        tx_expect  = rw & sel;
        tx_word    = data;
        tx_idx     = 0;
        tx_req_cnt = 0;
        tx_data    = data[7:0];
        if (bus_busy) repStart();
        else startCond();
        bus_busy     = 1'b1;
        exp_selected = sel;
        checkOutput({tag, "_busy"}, busy, 1'b1);
        sendByte({addr, rw}, ack);
        checkOutput({tag, "_addr_ack"}, ack, sel);
        checkOutput({tag, "_addr_match"}, addr_match, sel);
        if (!rw) begin
            for (int i = 0; i < n; i++) begin
                b = data[8*i +: 8];
                if (sel) rx_q.push_back(b);
                sendByte(b, ack);
                checkOutput({tag, "_data_ack"}, ack, sel);
            end
            checkOutput({tag, "_rx_pending"}, rx_q.size(), 0);
        end else if (sel) begin
            for (int i = 0; i < n; i++) begin
                readByte(i != n - 1, b);
                last_read = b;
                checkOutput({tag, "_read_byte"}, b, data[8*i +: 8]);
            end
            checkOutput({tag, "_tx_req_count"}, tx_req_cnt, n);
            tx_expect = 1'b0;
        end
        if (do_stop) finishStop(tag);
    endtask

    // Per-cycle compare: released SDA when not selected, receive bytes in order, requests only on reads
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (!exp_selected) checkOutput("sda_oe_unselected", sda_oe, 1'b0);
                if (rx_valid) begin
                    rxv_cnt++;
                    if (rx_q.size() == 0) checkOutput("rx_valid_unexpected", rx_valid, 1'b0);
                    else checkOutput("rx_data", rx_data, rx_q.pop_front());
                end
                if (tx_req) begin
                    if (!tx_expect) checkOutput("tx_req_unexpected", tx_req, 1'b0);
                    tx_req_cnt++;
                    tx_idx++;
                    tx_data = tx_word[8*(tx_idx % 4) +: 8];
                end
            end
        end
    end

    // Watchdog so a stuck bench still reports
    initial begin
        #800us;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized transfers
    initial begin
        logic       s;
        logic       ack;
        logic [7:0] b8;
        int         rxv_before;
        logic [6:0] a;
        logic       rw;
        int         n;
        rst      = 1'b1;
        m_scl    = 1'b1;
        m_sda    = 1'b1;
        own_addr = 7'h10;
        tx_data  = 8'h00;
        waitClk(5);
        #1;
        checkOutput("reset_sda_oe", sda_oe, 1'b0);
        checkOutput("reset_tx_req", tx_req, 1'b0);
        checkOutput("reset_rx_valid", rx_valid, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_addr_match", addr_match, 1'b0);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        waitClk(5);

        $display("[TB] write 0x80 to 0x10");
        rxv_before = rxv_cnt;
        applyStimulus("t1", 7'h10, 1'b0, 1, 32'h80, 1'b1);
        checkOutput("t1_rx_data", rx_data, 8'h80);
        checkOutput("t1_rx_valid_pulses", rxv_cnt - rxv_before, 1);

        $display("[TB] read 0xA5 with NACK");
        applyStimulus("t2", 7'h10, 1'b1, 1, 32'hA5, 1'b0);
        checkOutput("t2_read_literal", last_read, 8'hA5);
        waitClk(4);
        checkOutput("t2_wait_stop_busy", busy, 1'b1);
        checkOutput("t2_wait_stop_oe", sda_oe, 1'b0);
        finishStop("t2");

        $display("[TB] address mismatch");
        own_addr = 7'h11;
        waitClk(4);
        rxv_before = rxv_cnt;
        applyStimulus("t3", 7'h10, 1'b0, 1, 32'h5A, 1'b1);
        checkOutput("t3_no_rx_valid", rxv_cnt - rxv_before, 0);

        $display("[TB] write then repeated start read");
        own_addr = 7'h10;
        waitClk(4);
        applyStimulus("t4w", 7'h10, 1'b0, 1, 32'h3C, 1'b0);
        own_addr = 7'h55;
        applyStimulus("t4r", 7'h10, 1'b1, 3, 32'h030201, 1'b1);
        checkOutput("t4_rx_data", rx_data, 8'h3C);
        checkOutput("t4_last_read", last_read, 8'h03);
        own_addr = 7'h10;
        waitClk(4);

        $display("[TB] stop mid-byte");
        rxv_before = rxv_cnt;
        startCond();
        bus_busy     = 1'b1;
        exp_selected = 1'b1;
        sendByte(8'h20, ack);
        checkOutput("t5_addr_ack", ack, 1'b1);
        b8 = 8'hA0;
        for (int i = 7; i >= 4; i--) clockBit(b8[i], s);
        finishStop("t5");
        checkOutput("t5_rx_data_kept", rx_data, 8'h3C);
        checkOutput("t5_no_rx_valid", rxv_cnt - rxv_before, 0);

        $display("[TB] reset during address ACK");
        startCond();
        bus_busy     = 1'b1;
        exp_selected = 1'b1;
        b8 = 8'h20;
        for (int i = 7; i >= 0; i--) clockBit(b8[i], s);
        for (int k = 0; k < 20 && !sda_oe; k++) @(negedge clk);
        checkOutput("t6_pre_reset_oe", sda_oe, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6_reset_oe", sda_oe, 1'b0);
        checkOutput("t6_reset_busy", busy, 1'b0);
        checkOutput("t6_reset_match", addr_match, 1'b0);
        checkOutput("t6_reset_rx_data", rx_data, 8'h00);
        checkOutput("t6_reset_tx_req", tx_req, 1'b0);
        checkOutput("t6_reset_rx_valid", rx_valid, 1'b0);
        @(negedge clk);
        rst          = 1'b0;
        exp_selected = 1'b0;
        @(negedge clk);
        checkOutput("t6_post_reset_oe", sda_oe, 1'b0);
        clockBit(1'b1, s);
        checkOutput("t6_ack_released", s, 1'b1);
        stopCond();
        bus_busy = 1'b0;
        waitClk(4);
        applyStimulus("t6w", 7'h10, 1'b0, 1, 32'h99, 1'b1);
        checkOutput("t6_rx_data", rx_data, 8'h99);

        $display("[TB] randomized transfers");
        for (int t = 0; t < 24; t++) begin
            if (!bus_busy) begin
                own_addr = 7'($urandom_range(0, 127));
                waitClk(3);
            end
            a  = ($urandom_range(0, 3) != 0) ? (bus_busy ? model_own : own_addr)
                                               : 7'($urandom_range(0, 127));
            rw = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 3);
            applyStimulus("rnd", a, rw, n, $urandom, ($urandom_range(0, 1) == 1));
        end
        if (bus_busy) finishStop("rnd_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) endpoint: the responding end of the bus driven by the team's I2C master (finalproject).
- Samples SCL/SDA in the system clock domain; detects START/STOP; matches a 7-bit address.
- Receives write bytes into rx_data and serves read bytes from tx_data, ACKing on SDA via an open-drain enable.
- Single byte-level handshake toward the local register/data logic.

Parameters:
- SYNC_STAGES, 2, flops in the SCL/SDA input synchronizer (minimum 2).
- ADDR_W, 7, target address width (only 7 is supported; the parameter exists for the package constant).

Ports:
- clk  in  1  system clock; SCL must be at most clk/8.
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  SCL pin value (asynchronous).
- sda_in  in  1  SDA pin value (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release SDA.
- own_addr  in  7  target address; sampled only while idle.
- tx_data  in  8  next byte to return on a read.
- tx_req  out  1  1-clk pulse when tx_data has been latched; local logic must present the next byte before the next latch.
- rx_data  out  8  last byte received on a write.
- rx_valid  out  1  1-clk pulse when rx_data updates.
- busy  out  1  high from START to STOP.
- addr_match  out  1  high while this target is selected in the current transfer.

Behaviour:
- Reset values:
  - sda_oe=0, tx_req=0, rx_valid=0, busy=0, addr_match=0, rx_data=8'h00.
  - Synchronizers are reset to 1 (idle bus); state=IDLE.
- Input path:
  - SYNC_STAGES flops, plus one history flop per line.
  - scl_rise/scl_fall/sda_rise/sda_fall are 1-clk pulses.
  - Pin-to-event latency is SYNC_STAGES+1 clk.
- Bus conditions:
  - START = sda_fall while synced SCL is high.
  - STOP = sda_rise while synced SCL is high.
  - These have priority over every state and bit event.
- START, from any state, including a repeated START:
  - State goes to ADDR; bit counter=0; sda_oe=0; busy=1; addr_match=0.
- STOP, from any state:
  - State goes to IDLE; sda_oe=0; busy=0; addr_match=0.
- Bit timing:
  - Shift in on scl_rise, MSB first.
  - Change the driven SDA only on scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address bits + R/W).
    - After the 8th scl_rise, if addr==own_addr: set addr_match=1 and assert sda_oe=1 at the next scl_fall, entering ADDR_ACK.
    - Otherwise go to WAIT_STOP with sda_oe left at 0.
  - ADDR_ACK: at the scl_fall ending the ACK bit:
    - R/W=0: go to WRITE and release SDA.
    - R/W=1: latch tx_data into the shift register, pulse tx_req, drive bit 7 (sda_oe = ~bit), enter READ.
  - WRITE: shift 8 bits.
    - At the 8th scl_rise: load rx_data and pulse rx_valid the next clk.
    - At the next scl_fall: sda_oe=1, enter WRITE_ACK.
  - WRITE_ACK: at scl_fall release SDA and return to WRITE. The target always ACKs; there is no NACK-on-full.
  - READ: on each scl_fall drive the next bit.
    - After the 8th bit's scl_fall, release SDA and enter READ_ACK.
  - READ_ACK: sample SDA at scl_rise.
    - 0 (ACK): at scl_fall latch tx_data, pulse tx_req, drive bit 7, return to READ.
    - 1 (NACK): go to WAIT_STOP with SDA released.
  - WAIT_STOP: SDA released; leave only on STOP or START.
- Width rules:
  - The bit counter is 3 bits; wrap from 7 to 0 marks a byte boundary.
  - The address comparison uses shift[7:1]; R/W is shift[0].
- Other boundary conditions:
  - A STOP or START mid-byte discards the partial byte; no rx_valid is issued.
  - own_addr changes during busy are ignored until IDLE.
  - rst mid-transfer returns all outputs to reset values on the next clk edge and releases SDA immediately.
  - The target never stretches SCL.

Decomposition:
- Package i2c_pkg:
  - i2c_state_t enum {IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP}.
  - I2C_ADDR_W=7, I2C_RW_READ=1'b1.
- One sub-module, i2c_sync_edge: synchronizer plus edge/START/STOP detector for SCL/SDA, reusable by the master.

Test Plan:
- own_addr=7'h10; START, byte 8'h20, data 8'h80, STOP -> ACK (SDA low) on both ACK slots; rx_data=8'h80 with one rx_valid pulse; busy falls after STOP.
- own_addr=7'h10, tx_data=8'hA5; START, byte 8'h21, master NACKs after one byte -> SDA bits 1,0,1,0,0,1,0,1; one tx_req pulse; WAIT_STOP then IDLE on STOP.
- own_addr=7'h11; START, byte 8'h20 -> sda_oe stays 0 throughout; addr_match=0; no rx_valid after a following data byte.
- Write 8'h20, 8'h3C, then repeated START, 8'h21, master ACKs twice then NACKs with tx_data 8'h01/8'h02/8'h03 -> rx_data=8'h3C; bytes read back 01,02,03; three tx_req pulses.
- STOP after 4 data bits of a write -> no rx_valid; rx_data unchanged; state IDLE; sda_oe=0.
- Assert rst for 1 clk while the target is driving SDA low in ADDR_ACK -> sda_oe=0 on the next edge; all outputs at reset values; the next full write transfer succeeds.
